// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack card path.
// Holds the card shoe state encoding, LFSR feedback mask, display codes
// used by the game controller, and the rank-to-value helper.
package blackjack_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    RELOAD = 2'd2,
    EMIT   = 2'd3
  } shoe_state_t;

  localparam int          RANKS       = 13;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [5:0]  ACE_CODE    = 6'd61;
  localparam logic [5:0]  BET_CODE    = 6'd62;
  localparam logic [5:0]  DEALER_CODE = 6'd63;

  // Blackjack value of a rank 1..13: ace = 1, pips face value, J/Q/K = 10.
  // Ranks outside 1..13 never occur and map to 0.
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    logic [3:0] value_s;
    case (rank)
      4'd11, 4'd12, 4'd13: value_s = 4'd10;
      4'd0, 4'd14, 4'd15:  value_s = 4'd0;
      default:             value_s = rank;
    endcase
    return value_s;
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Draw handshake between the blackjack game controller and the card shoe.
//   draw_req/shuffle_req/test : controller -> shoe requests (sampled in IDLE)
//   card_valid/value/rank     : one-cycle card delivery from the shoe
//   busy/cards_left           : shoe status
// modport master = game controller, modport slave = card shoe.
interface card_shoe_if;
  logic       draw_req;
  logic       shuffle_req;
  logic [2:0] test;
  logic       card_valid;
  logic [3:0] card_value;
  logic [3:0] card_rank;
  logic       busy;
  logic [8:0] cards_left;

  modport master (
    output draw_req, shuffle_req, test,
    input  card_valid, card_value, card_rank, busy, cards_left
  );

  modport slave (
    input  draw_req, shuffle_req, test,
    output card_valid, card_value, card_rank, busy, cards_left
  );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift, mask LFSR_MASK).
// Ports: clk, reset (async, active-high), seed_load/seed (load has priority
// over the advance; a zero seed is replaced by SEED because the all-zero
// state would lock up), value (current LFSR state).
module lfsr16
  import blackjack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_r;
  logic [15:0] shift_s;

  // Next state of the Galois shift: feed the dropped bit back through the mask.
  always_comb begin
    shift_s = {1'b0, value_r[15:1]};
    if (value_r[0]) begin
      shift_s = shift_s ^ LFSR_MASK;
    end else begin
      shift_s = {1'b0, value_r[15:1]};
    end
  end

  // LFSR register: seed load wins over the per-cycle advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r <= SEED;
    end else if (seed_load) begin
      value_r <= (seed == 16'h0000) ? SEED : seed;
    end else begin
      value_r <= shift_s;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/card_shoe.sv
// Finite multi-deck card shoe feeding the blackjack controller.
// Ports: clk, reset (async, active-high), seed_load/seed (LFSR seeding),
// bus (card_shoe_if.slave: draw_req, shuffle_req, test in; card_valid,
// card_value, card_rank, busy, cards_left out).
// A draw starts at a random rank taken from the LFSR and walks forward
// through the ranks until one with cards left is found, so cards are never
// redrawn before a reshuffle. An empty shoe reloads itself on the next draw.
module card_shoe
  import blackjack_pkg::*;
#(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seed_load,
  input  logic [15:0]   seed,
  card_shoe_if.slave    bus
);

  localparam logic [5:0] FULL_COUNT = 6'(4 * NUM_DECKS);
  localparam logic [8:0] FULL_SHOE  = 9'(52 * NUM_DECKS);

  shoe_state_t state_r;
  logic [5:0]  count_r [RANKS];
  logic [8:0]  cards_left_r;
  logic [3:0]  idx_r;
  logic        cont_r;
  logic        card_valid_r;
  logic [3:0]  card_value_r;
  logic [3:0]  card_rank_r;
  logic        busy_r;

  logic [15:0] lfsr_s;
  logic [3:0]  start_idx_s;
  logic [3:0]  next_idx_s;
  logic        unused_lfsr_s;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed      (seed),
    .value     (lfsr_s)
  );

  // Only the low nibble picks the start rank.
  assign unused_lfsr_s = ^lfsr_s[15:4];

  // Start rank from the LFSR nibble, folding 13..15 back onto 0..2,
  // and the wrapping successor of the current probe index.
  always_comb begin
    if (lfsr_s[3:0] >= 4'd13) begin
      start_idx_s = lfsr_s[3:0] - 4'd13;
    end else begin
      start_idx_s = lfsr_s[3:0];
    end
    if (idx_r == 4'd12) begin
      next_idx_s = 4'd0;
    end else begin
      next_idx_s = idx_r + 4'd1;
    end
  end

  // Shoe controller: state, rank counts and registered outputs.
  // card_valid is raised on entry to EMIT so it is high for the EMIT cycle;
  // busy tracks the state being entered so it is low exactly in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      for (int i = 0; i < RANKS; i++) begin
        count_r[i] <= FULL_COUNT;
      end
      cards_left_r <= FULL_SHOE;
      idx_r        <= 4'd0;
      cont_r       <= 1'b0;
      card_valid_r <= 1'b0;
      card_value_r <= 4'd0;
      card_rank_r  <= 4'd0;
      busy_r       <= 1'b0;
    end else begin
      card_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.draw_req) begin
            idx_r  <= start_idx_s;
            busy_r <= 1'b1;
            if (bus.test != 3'd0) begin
              card_rank_r  <= {1'b0, bus.test};
              card_value_r <= {1'b0, bus.test};
              card_valid_r <= 1'b1;
              state_r      <= EMIT;
            end else if (bus.shuffle_req || (cards_left_r == 9'd0)) begin
              cont_r  <= 1'b1;
              state_r <= RELOAD;
            end else begin
              state_r <= PROBE;
            end
          end else if (bus.shuffle_req) begin
            cont_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= RELOAD;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        PROBE: begin
          if (count_r[idx_r] != 6'd0) begin
            count_r[idx_r] <= count_r[idx_r] - 6'd1;
            cards_left_r   <= cards_left_r - 9'd1;
            card_rank_r    <= idx_r + 4'd1;
            card_value_r   <= rank_to_value(idx_r + 4'd1);
            card_valid_r   <= 1'b1;
            state_r        <= EMIT;
          end else begin
            idx_r   <= next_idx_s;
            state_r <= PROBE;
          end
        end
        RELOAD: begin
          for (int i = 0; i < RANKS; i++) begin
            count_r[i] <= FULL_COUNT;
          end
          cards_left_r <= FULL_SHOE;
          cont_r       <= 1'b0;
          if (cont_r) begin
            state_r <= PROBE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        EMIT: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.card_valid = card_valid_r;
  assign bus.card_value = card_value_r;
  assign bus.card_rank  = card_rank_r;
  assign bus.busy       = busy_r;
  assign bus.cards_left = cards_left_r;

endmodule
